// File: rtl/jtframe_sdram_pkg.sv
// Shared types and default sizes for the SDRAM read-port arbiter.
package jtframe_sdram_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Client request bus plus SDRAM read handshake seen by the arbiter.
interface jtframe_sdram_arb_if
  import jtframe_sdram_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    sel;
  logic               sdram_req;
  logic               sdram_ack;
  logic               data_rdy;
  logic [AW-1:0]      sdram_addr;

  modport slave (
    input  req, addr, sdram_ack, data_rdy,
    output sel, sdram_req, sdram_addr
  );

  modport master (
    output req, addr, sdram_ack, data_rdy,
    input  sel, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin pick: first set bit of valid after ptr, wrapping.
module jtframe_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            found
);

  logic [PW-1:0] idx;

  // Scan from lowest to highest priority so the closest candidate after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among ROM clients, with watchdog re-issue.
module jtframe_sdram_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = 64,
  parameter int RDYW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  jtframe_sdram_arb_if.slave  bus,
  output logic                refresh_en,
  output logic                ready,
  output logic                timeout
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] sel_q, sel_d;
  logic            sdram_req_q, sdram_req_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [RDYW-1:0] rdy_cnt_q, rdy_cnt_d;
  logic            ready_q, ready_d;
  logic            timeout_q, timeout_d;
  logic            refresh_q, refresh_d;

  logic            clear;
  logic [NREQ-1:0] valid;
  logic [PW-1:0]   win;
  logic            found;
  logic            try_grant;
  logic [NREQ-1:0] win_onehot;
  logic [AW-1:0]   win_addr;

  assign clear = downloading | loop_rst;
  // The client being served is masked so it cannot win twice in a row.
  assign valid = bus.req & ~sel_q;

  jtframe_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid (valid),
    .ptr   (ptr_q),
    .win   (win),
    .found (found)
  );

  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_onehot[i] = 1'b1;
        win_addr      = bus.addr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    ptr_d        = ptr_q;
    wd_d         = wd_q;
    timeout_d    = 1'b0;
    try_grant    = 1'b0;
    rdy_cnt_d    = ready_q ? rdy_cnt_q : rdy_cnt_q + 1'b1;
    ready_d      = ready_q | (&rdy_cnt_q);
    refresh_d    = (state_q == IDLE) && (bus.req == '0);

    case (state_q)
      IDLE: try_grant = 1'b1;
      REQ: begin
        // data_rdy here implies the ack was merged into the same cycle.
        if (bus.data_rdy) begin
          sel_d       = '0;
          sdram_req_d = 1'b0;
          state_d     = IDLE;
          try_grant   = 1'b1;
        end else if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          wd_d        = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.data_rdy) begin
          sel_d       = '0;
          sdram_req_d = 1'b0;
          state_d     = IDLE;
          try_grant   = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          sdram_req_d = 1'b1;
          timeout_d   = 1'b1;
          wd_d        = '0;
          state_d     = REQ;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (try_grant && found) begin
      ptr_d        = win;
      sel_d        = win_onehot;
      sdram_addr_d = win_addr;
      sdram_req_d  = 1'b1;
      state_d      = REQ;
    end

    if (clear) begin
      state_d      = IDLE;
      sel_d        = '0;
      sdram_req_d  = 1'b0;
      sdram_addr_d = '0;
      ptr_d        = PW'(NREQ - 1);
      wd_d         = '0;
      rdy_cnt_d    = '0;
      ready_d      = 1'b0;
      timeout_d    = 1'b0;
      refresh_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      ptr_q        <= PW'(NREQ - 1);
      wd_q         <= '0;
      rdy_cnt_q    <= '0;
      ready_q      <= 1'b0;
      timeout_q    <= 1'b0;
      refresh_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      rdy_cnt_q    <= rdy_cnt_d;
      ready_q      <= ready_d;
      timeout_q    <= timeout_d;
      refresh_q    <= refresh_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign refresh_en     = refresh_q;
  assign ready          = ready_q;
  assign timeout        = timeout_q;

endmodule
